// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and limits for the clk1 divider controller
package clk_div_pkg;

   typedef enum logic [1:0] {OFF, RUN, SWITCH} state_t;

   localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter, divisor register and registered clk2/clk2_en generation
module clk_div_core #(
   parameter int               DIV_W = 8,
   parameter logic [DIV_W-1:0] RST_N = 2
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             go,
   input  logic             start,
   input  logic             ld,
   input  logic [DIV_W-1:0] n_in,
   output logic             wrap,
   output logic [DIV_W-1:0] n,
   output logic             clk2,
   output logic             clk2_en
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nx;

   assign wrap   = (cnt == n - 1'b1);
   assign cnt_nx = wrap ? '0 : cnt + 1'b1;

   // clk2 is registered from the next count, so high phase spans cnt 0..floor(N/2)-1
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         n       <= RST_N;
         clk2    <= 1'b0;
         clk2_en <= 1'b0;
      end else begin
         if (!go) begin
            cnt     <= '0;
            clk2    <= 1'b0;
            clk2_en <= 1'b0;
         end else if (start) begin
            cnt     <= '0;
            clk2    <= 1'b1;
            clk2_en <= 1'b1;
         end else begin
            cnt     <= cnt_nx;
            clk2    <= (cnt_nx < (n >> 1));
            clk2_en <= wrap;
         end
         if (ld)
            n <= n_in;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - divider FSM, divisor handshake and optional period monitor
// Optional monitor ports enabled by CLK_DIV_CTRL_PERIOD_MON_EN.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_valid,
   output logic             div_ready,
   output logic             clk2,
   output logic             clk2_en,
   output logic             locked,
`ifdef CLK_DIV_CTRL_PERIOD_MON_EN
   output logic [DIV_W-1:0] meas_period,
   output logic             period_err,
`endif
   output logic             busy
);

   localparam logic [DIV_W-1:0] MIN_N = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] DEF_N = (DEF_DIV < MIN_DIV) ? MIN_N : DIV_W'(DEF_DIV);

   state_t           state;
   logic [DIV_W-1:0] n_pend;
   logic [DIV_W-1:0] n;
   logic [DIV_W-1:0] dv;
   logic [DIV_W-1:0] n_in;
   logic             acc, go, start, ld, wrap;

   assign acc = div_valid & div_ready;
   assign dv  = (div_val < MIN_N) ? MIN_N : div_val;

   // A pending divisor is applied either at the old period's last cycle or on dropping en
   always_comb begin
      go    = en;
      start = 1'b0;
      ld    = 1'b0;
      n_in  = dv;
      case (state)
         OFF: begin
            start = en;
            ld    = acc;
         end
         RUN: begin
            ld = acc & ~en;
         end
         SWITCH: begin
            start = en & wrap;
            ld    = ~en | wrap;
            n_in  = n_pend;
         end
         default: begin
            go = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state     <= OFF;
         n_pend    <= DEF_N;
         locked    <= 1'b0;
         busy      <= 1'b0;
         div_ready <= 1'b1;
      end else begin
         case (state)
            OFF: begin
               locked <= 1'b0;
               if (en)
                  state <= RUN;
            end
            RUN: begin
               if (!en) begin
                  state  <= OFF;
                  locked <= 1'b0;
               end else begin
                  if (wrap)
                     locked <= 1'b1;
                  if (acc) begin
                     state     <= SWITCH;
                     n_pend    <= dv;
                     busy      <= 1'b1;
                     div_ready <= 1'b0;
                  end
               end
            end
            SWITCH: begin
               if (!en || wrap) begin
                  state     <= en ? RUN : OFF;
                  locked    <= 1'b0;
                  busy      <= 1'b0;
                  div_ready <= 1'b1;
               end
            end
            default: begin
               state     <= OFF;
               locked    <= 1'b0;
               busy      <= 1'b0;
               div_ready <= 1'b1;
            end
         endcase
      end
   end

   clk_div_core #(.DIV_W(DIV_W), .RST_N(DEF_N)) u_core (
      .clk1    (clk1),
      .rst     (rst),
      .go      (go),
      .start   (start),
      .ld      (ld),
      .n_in    (n_in),
      .wrap    (wrap),
      .n       (n),
      .clk2    (clk2),
      .clk2_en (clk2_en)
   );

`ifdef CLK_DIV_CTRL_PERIOD_MON_EN
   logic [DIV_W-1:0] since;
   logic [DIV_W-1:0] n_at;
   logic             seen;

   // Periods whose divisor changed between pulses are not judged
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         since       <= '0;
         n_at        <= '0;
         seen        <= 1'b0;
         meas_period <= '0;
         period_err  <= 1'b0;
      end else if (state == OFF) begin
         since      <= '0;
         seen       <= 1'b0;
         period_err <= 1'b0;
      end else if (clk2_en) begin
         seen  <= 1'b1;
         since <= DIV_W'(1);
         n_at  <= n;
         if (seen) begin
            meas_period <= since;
            if (n_at == n && since != n)
               period_err <= 1'b1;
         end
      end else if (since != '1) begin
         since <= since + 1'b1;
      end
   end
`else
   logic unused_mon;
   assign unused_mon = ^n;
`endif

endmodule
